// File: rtl/frame_bus_arbiter_if.sv
// Client-side bundle for the frame memory arbiter: clear control, scan read port
// and two packed writer ports (writer 1 in the upper slice of each vector).
interface frame_bus_arbiter_if;
  logic        clr;
  logic        busy;
  logic        scan_req;
  logic [2:0]  scan_row;
  logic        scan_vld;
  logic [15:0] scan_data;
  logic [1:0]  w_req;
  logic [5:0]  w_row;
  logic [3:0]  w_op;
  logic [31:0] w_data;
  logic [1:0]  w_done;

  modport slave (
    input  clr, scan_req, scan_row, w_req, w_row, w_op, w_data,
    output busy, scan_vld, scan_data, w_done
  );

  modport master (
    output clr, scan_req, scan_row, w_req, w_row, w_op, w_data,
    input  busy, scan_vld, scan_data, w_done
  );
endinterface

// File: rtl/frame_bus_arbiter.sv
// Single-port owner of the 8x16 dot-matrix frame: arbitrates clear > scan > writers,
// with round-robin between writers and a two-cycle read-modify-write path.
module frame_bus_arbiter (
  input  logic               clk,
  input  logic               rst,
  frame_bus_arbiter_if.slave bus
);
  localparam int ROWS   = 8;
  localparam int COLS   = 16;
  localparam int RW     = $clog2(ROWS);
  localparam int NUM_WR = 2;

  typedef enum logic [1:0] {IDLE, RMW_WR, CLEAR} state_t;
  typedef enum logic [1:0] {OP_WR, OP_OR, OP_ANDN, OP_SHL} op_t;
  typedef struct packed {
    logic [RW-1:0]   row;
    op_t             op;
    logic [COLS-1:0] data;
  } wreq_t;

  state_t                    state, state_d;
  logic [ROWS-1:0][COLS-1:0] mem;
  wreq_t [NUM_WR-1:0]        wreq;
  wreq_t                     gnt_req, rmw_q;
  logic [COLS-1:0]           rd_q, rmw_res;
  logic                      rr, gnt_idx, rmw_idx;
  logic [RW-1:0]             clr_cnt;
  logic                      gnt_clr, gnt_scan, gnt_wr, commit;

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    assign wreq[i] = '{row:  bus.w_row[RW*i +: RW],
                       op:   op_t'(bus.w_op[2*i +: 2]),
                       data: bus.w_data[COLS*i +: COLS]};
  end

  assign gnt_req = wreq[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // A lone requester wins outright; rr only breaks ties.
  always_comb begin
    state_d  = state;
    gnt_clr  = 1'b0;
    gnt_scan = 1'b0;
    gnt_wr   = 1'b0;
    commit   = 1'b0;
    gnt_idx  = (&bus.w_req) ? rr : bus.w_req[1];
    case (state)
      IDLE: begin
        if (bus.clr) begin
          gnt_clr = 1'b1;
          state_d = CLEAR;
        end else if (bus.scan_req) begin
          gnt_scan = 1'b1;
        end else if (|bus.w_req) begin
          gnt_wr = 1'b1;
          if (gnt_req.op != OP_WR) state_d = RMW_WR;
        end
      end
      RMW_WR: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      CLEAR: if (clr_cnt == RW'(ROWS-1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rmw_res = rmw_q.data;
    case (rmw_q.op)
      OP_OR:   rmw_res = rd_q | rmw_q.data;
      OP_ANDN: rmw_res = rd_q & ~rmw_q.data;
      OP_SHL:  rmw_res = {rd_q[COLS-2:0], 1'b0};
      default: rmw_res = rmw_q.data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem           <= '0;
      rr            <= 1'b0;
      bus.busy      <= 1'b0;
      bus.scan_vld  <= 1'b0;
      bus.scan_data <= '0;
      bus.w_done    <= '0;
      clr_cnt       <= '0;
      rd_q          <= '0;
      rmw_q         <= '0;
      rmw_idx       <= 1'b0;
    end else begin
      bus.scan_vld <= gnt_scan;
      bus.w_done   <= '0;
      if (gnt_scan) bus.scan_data <= mem[bus.scan_row];
      if (gnt_clr) begin
        bus.busy <= 1'b1;
        clr_cnt  <= '0;
      end
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
        clr_cnt      <= clr_cnt + 1'b1;
        if (clr_cnt == RW'(ROWS-1)) bus.busy <= 1'b0;
      end
      if (gnt_wr) begin
        rr <= ~gnt_idx;
        if (gnt_req.op == OP_WR) begin
          mem[gnt_req.row]    <= gnt_req.data;
          bus.w_done[gnt_idx] <= 1'b1;
        end else begin
          rmw_q   <= gnt_req;
          rmw_idx <= gnt_idx;
          rd_q    <= mem[gnt_req.row];
        end
      end
      if (commit) begin
        mem[rmw_q.row]      <= rmw_res;
        bus.w_done[rmw_idx] <= 1'b1;
      end
    end
  end

  a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(&bus.w_done));
  a_done_scan:   assert property (@(posedge clk) disable iff (rst) !(bus.scan_vld && |bus.w_done));
endmodule

// File: tb/tb_frame_bus_arbiter.sv
// Bench for frame_bus_arbiter: directed vector table, hand-written clear/contention/reset
// sequences, then random transactions checked against a row-array reference model.
module tb_frame_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_bus_arbiter_if bus();
  frame_bus_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  logic [15:0] mem_m [8];
  int          rr_m;
  logic [2:0]  wr_row  [2];
  logic [1:0]  wr_op   [2];
  logic [15:0] wr_data [2];

  typedef struct {
    bit          kind;   // 0 scan, 1 write
    bit          idx;
    logic [2:0]  row;
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] apply(input logic [15:0] old, input logic [1:0] op,
                                        input logic [15:0] d);
    case (op)
      2'd0:    return d;
      2'd1:    return old | d;
      2'd2:    return old & ~d;
      default: return old << 1;
    endcase
  endfunction

  function automatic int oplat(input logic [1:0] op);
    return (op == 2'd0) ? 1 : 2;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++) mem_m[r] = 16'h0;
  endtask

  task automatic do_scan(input logic [2:0] row, output logic [15:0] data, output int lat);
    bit got = 0;
    bus.scan_req = 1'b1;
    bus.scan_row = row;
    lat = -1;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (bus.scan_vld) begin
        got = 1;
        lat = n;
      end
    end
    data = bus.scan_data;
    bus.scan_req = 1'b0;
    if (!got) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_writers(input logic [1:0] mask, output int c0, output int c1,
                             output int first);
    logic [1:0] pend;
    int n;
    bus.w_row  = {wr_row[1], wr_row[0]};
    bus.w_op   = {wr_op[1], wr_op[0]};
    bus.w_data = {wr_data[1], wr_data[0]};
    bus.w_req  = mask;
    pend = mask; c0 = -1; c1 = -1; first = -1; n = 0;
    while (pend != 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
      chk("done_excl", {31'd0, (&bus.w_done) | (|bus.w_done & bus.scan_vld)}, 32'd0);
      chk("done_spurious", {30'd0, bus.w_done & ~pend}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        if (pend[k] && bus.w_done[k]) begin
          if (k == 0) c0 = n; else c1 = n;
          if (first < 0) first = k;
          pend[k] = 1'b0;
          bus.w_req[k] = 1'b0;
        end
      end
    end
    if (pend != 2'b00) chk("w_timeout", {30'd0, pend}, 32'd0);
    bus.w_req = 2'b00;
  endtask

  task automatic single_write(input bit idx, input logic [2:0] row, input logic [1:0] op,
                              input logic [15:0] data, output int lat);
    int c0, c1, first;
    wr_row[idx] = row; wr_op[idx] = op; wr_data[idx] = data;
    run_writers(idx ? 2'b10 : 2'b01, c0, c1, first);
    lat = idx ? c1 : c0;
    mem_m[row] = apply(mem_m[row], op, data);
    rr_m = idx ? 0 : 1;
  endtask

  task automatic dual_write();
    int c0, c1, first, f, s, lf, ls;
    f = rr_m; s = 1 - f;
    run_writers(2'b11, c0, c1, first);
    chk("dual_first", first, f);
    lf = oplat(wr_op[f]);
    ls = oplat(wr_op[s]);
    chk("dual_lat_first", (f == 0) ? c0 : c1, lf);
    chk("dual_lat_second", (f == 0) ? c1 : c0, lf + ls);
    mem_m[wr_row[f]] = apply(mem_m[wr_row[f]], wr_op[f], wr_data[f]);
    mem_m[wr_row[s]] = apply(mem_m[wr_row[s]], wr_op[s], wr_data[s]);
    rr_m = f;
  endtask

  // Clear takes 8 busy cycles; a scan raised alongside clr is served right after.
  task automatic do_clear(input bit with_scan, input bit reclr);
    int busy_n = 0, last_busy = 0, vld_at = -1;
    logic [15:0] sd = 16'hxxxx;
    bus.clr = 1'b1;
    if (with_scan) begin
      bus.scan_req = 1'b1;
      bus.scan_row = 3'd4;
    end
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      bus.clr = reclr && (n == 3);
      if (bus.busy) begin
        busy_n++;
        last_busy = n;
        chk("clr_no_vld", {31'd0, bus.scan_vld}, 32'd0);
      end
      if (bus.scan_vld && vld_at < 0) begin
        vld_at = n;
        sd = bus.scan_data;
        bus.scan_req = 1'b0;
      end
    end
    chk("clr_busy_cycles", busy_n, 8);
    chk("clr_busy_last", last_busy, 8);
    if (with_scan) begin
      chk("clr_scan_at", vld_at, 10);
      chk("clr_scan_data", sd, 16'h0);
    end
    model_clear();
  endtask

  initial begin
    logic [15:0] sd;
    int lat, r;
    logic [2:0] row;

    bus.clr = 0; bus.scan_req = 0; bus.scan_row = 0;
    bus.w_req = 0; bus.w_row = 0; bus.w_op = 0; bus.w_data = 0;
    rst = 1'b1; rr_m = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_scan_vld", {31'd0, bus.scan_vld}, 32'd0);
    chk("rst_scan_data", bus.scan_data, 16'h0);
    chk("rst_w_done", {30'd0, bus.w_done}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) tbl.push_back('{0, 0, 3'(k), 2'd0, 16'h0, 16'h0000, 1});
    tbl.push_back('{1, 0, 3'd3, 2'd0, 16'h0008, 16'h0, 1});
    tbl.push_back('{0, 0, 3'd3, 2'd0, 16'h0,    16'h0008, 1});
    tbl.push_back('{1, 0, 3'd3, 2'd0, 16'h8008, 16'h0, 1});
    tbl.push_back('{1, 1, 3'd3, 2'd3, 16'hFFFF, 16'h0, 2});
    tbl.push_back('{0, 0, 3'd3, 2'd0, 16'h0,    16'h0010, 1});
    tbl.push_back('{1, 0, 3'd2, 2'd0, 16'h00F0, 16'h0, 1});
    tbl.push_back('{1, 1, 3'd2, 2'd1, 16'h0F00, 16'h0, 2});
    tbl.push_back('{1, 0, 3'd2, 2'd2, 16'h0330, 16'h0, 2});
    tbl.push_back('{0, 0, 3'd2, 2'd0, 16'h0,    16'h0CC0, 1});
    tbl.push_back('{1, 0, 3'd7, 2'd0, 16'hFFFF, 16'h0, 1});
    tbl.push_back('{1, 1, 3'd7, 2'd3, 16'h1234, 16'h0, 2});
    tbl.push_back('{0, 0, 3'd7, 2'd0, 16'h0,    16'hFFFE, 1});

    foreach (tbl[k]) begin
      if (tbl[k].kind == 0) begin
        do_scan(tbl[k].row, sd, lat);
        chk($sformatf("tbl%0d_data", k), sd, tbl[k].exp);
      end else begin
        single_write(tbl[k].idx, tbl[k].row, tbl[k].op, tbl[k].data, lat);
      end
      chk($sformatf("tbl%0d_lat", k), lat, tbl[k].lat);
    end

    // Contention on one row: w0 wins first, w1's data lands last, pointer returns to w0.
    wr_row[0] = 3'd5; wr_op[0] = 2'd0; wr_data[0] = 16'h0001;
    wr_row[1] = 3'd5; wr_op[1] = 2'd0; wr_data[1] = 16'h0002;
    dual_write();
    do_scan(3'd5, sd, lat);
    chk("contend_row5", sd, 16'h0002);
    wr_row[0] = 3'd6; wr_data[0] = 16'h00AA;
    wr_row[1] = 3'd6; wr_data[1] = 16'h0055;
    dual_write();
    do_scan(3'd6, sd, lat);
    chk("contend_row6", sd, 16'h0055);

    do_clear(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      do_scan(3'(k), sd, lat);
      chk($sformatf("clr_row%0d", k), sd, 16'h0);
    end

    // Reset while an OR is between its read and its commit.
    single_write(1'b0, 3'd1, 2'd0, 16'h1234, lat);
    wr_row[0] = 3'd1; wr_op[0] = 2'd1; wr_data[0] = 16'h00FF;
    bus.w_row = {wr_row[1], wr_row[0]}; bus.w_op = {wr_op[1], wr_op[0]};
    bus.w_data = {wr_data[1], wr_data[0]};
    bus.w_req = 2'b01;
    @(negedge clk);
    chk("rmw_pre_done", {30'd0, bus.w_done}, 32'd0);
    rst = 1'b1;
    bus.w_req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    rr_m = 0;
    for (int n = 0; n < 3; n++) begin
      chk("rmw_rst_done", {30'd0, bus.w_done}, 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      do_scan(3'(k), sd, lat);
      chk($sformatf("rmw_rst_row%0d", k), sd, 16'h0);
      chk("rmw_rst_lat", lat, 1);
    end

    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_clear(1'b0, 1'($urandom_range(0, 1)));
      end else if (r < 35) begin
        row = 3'($urandom_range(0, 7));
        do_scan(row, sd, lat);
        chk("rnd_scan_data", sd, mem_m[row]);
        chk("rnd_scan_lat", lat, 1);
      end else if (r < 70) begin
        logic [1:0] op;
        bit idx;
        idx = 1'($urandom_range(0, 1));
        op  = 2'($urandom_range(0, 3));
        single_write(idx, 3'($urandom_range(0, 7)), op, 16'($urandom), lat);
        chk("rnd_wr_lat", lat, oplat(op));
      end else begin
        for (int k = 0; k < 2; k++) begin
          wr_row[k]  = 3'($urandom_range(0, 7));
          wr_op[k]   = 2'($urandom_range(0, 3));
          wr_data[k] = 16'($urandom);
        end
        dual_write();
      end
    end

    for (int k = 0; k < 8; k++) begin
      do_scan(3'(k), sd, lat);
      chk($sformatf("final_row%0d", k), sd, mem_m[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
